// File: rtl/alu_logic_serial.sv
// Bit-serial AND/OR/XOR/NOT engine with valid/ready request and response channels.
// Optional zero flag on the result is enabled by defining ALU_LOGIC_ZFLAG_EN.
module alu_logic_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef ALU_LOGIC_ZFLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             bit_s;
    logic [WIDTH-1:0] acc_bit_s;
    logic             last_s;

    function automatic logic logic_bit(input logic [1:0] sel, input logic a, input logic b);
        case (sel)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Current bit result and the accumulator with that bit merged in.
    always_comb begin
        bit_s           = logic_bit(op_q, x_q[cnt_q], y_q[cnt_q]);
        acc_bit_s       = acc_q;
        acc_bit_s[cnt_q] = bit_s;
        last_s          = (cnt_q == CNT_LAST);
    end

    // Next-state and datapath control for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        op_d        = op_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
                    op_d    = op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_bit_s;
                if (last_s) begin
                    result_d    = acc_bit_s;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            op_q        <= 2'b00;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

`ifdef ALU_LOGIC_ZFLAG_EN
    logic zero_q;

    // Zero flag loads with the result on completion and holds until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if ((state_q == ST_SHIFT) && last_s) begin
            zero_q <= (acc_bit_s == '0);
        end else begin
            zero_q <= zero_q;
        end
    end

    assign zero = zero_q;
`endif

endmodule
